// File: rtl/hfrv_retire_monitor.sv
// hfrv_retire_monitor: retire-port opcode coverage counters, ADDI result checker and FWFT trace FIFO.
// Optional HFRV_MON_STOP_ON_ERR_EN freezes sampling after the first ADDI mismatch until cnt_clear_i.
module hfrv_retire_monitor #(
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    input  logic                 retire_valid_i,
    input  logic [XLEN-1:0]      retire_pc_i,
    input  logic [31:0]          retire_inst_i,
    input  logic                 retire_rd_we_i,
    input  logic [XLEN-1:0]      retire_rd_wdata_i,
    input  logic [XLEN-1:0]      retire_rs1_val_i,
    input  logic                 cnt_clear_i,
    input  logic [3:0]           cnt_sel_i,
    output logic [CNT_WIDTH-1:0] cnt_value_o,
    output logic                 trace_valid_o,
    input  logic                 trace_ready_i,
    output logic [XLEN-1:0]      trace_pc_o,
    output logic [31:0]          trace_inst_o,
    output logic                 trace_overflow_o,
    output logic                 addi_err_o,
    output logic [XLEN-1:0]      addi_err_pc_o
);
    localparam int AW = $clog2(TRACE_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_e;
    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q [16];
    logic [CNT_WIDTH-1:0]  cnt_d [16];
    logic [CNT_WIDTH-1:0]  cnt_value_q;
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [XLEN+31:0]      mem_q [TRACE_DEPTH];
    logic [XLEN+31:0]      head;
    logic                  overflow_q, addi_err_q;
    logic [XLEN-1:0]       addi_err_pc_q, addi_exp;
    logic [6:0]            op;
    logic [3:0]            cls;
    logic                  accept, empty, full, pop, push, drop, addi_mis;
    assign op  = retire_inst_i[6:0];
    assign cls = op == 7'h37 ? 4'd0 : op == 7'h17 ? 4'd1 : op == 7'h6F ? 4'd2 :
                 op == 7'h67 ? 4'd3 : op == 7'h63 ? 4'd4 : op == 7'h03 ? 4'd5 :
                 op == 7'h23 ? 4'd6 : op == 7'h13 ? 4'd7 : op == 7'h33 ? 4'd8 :
                 op == 7'h0F ? 4'd9 : op == 7'h73 ? 4'd10 : 4'd11;
    // A clear in the same cycle wins over the retire: it is neither counted nor traced.
    assign accept = retire_valid_i && state_q == RUN && !cnt_clear_i;
    assign empty  = wr_ptr_q == rd_ptr_q;
    assign full   = wr_ptr_q[AW] != rd_ptr_q[AW] && wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0];
    assign pop    = !empty && trace_ready_i;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;
    assign addi_exp = retire_rs1_val_i + {{(XLEN-12){retire_inst_i[31]}}, retire_inst_i[31:20]};
    assign addi_mis = accept && op == 7'h13 && retire_inst_i[14:12] == 3'b000 &&
                      retire_inst_i[11:7] != 5'd0 && retire_rd_we_i && retire_rd_wdata_i != addi_exp;
    assign head = mem_q[rd_ptr_q[AW-1:0]];
    assign trace_valid_o    = !empty;
    assign trace_pc_o       = empty ? '0 : head[XLEN+31:32];
    assign trace_inst_o     = empty ? '0 : head[31:0];
    assign cnt_value_o      = cnt_value_q;
    assign trace_overflow_o = overflow_q;
    assign addi_err_o       = addi_err_q;
    assign addi_err_pc_o    = addi_err_pc_q;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (!enable_i) state_d = IDLE;
`ifdef HFRV_MON_STOP_ON_ERR_EN
                     else if (addi_mis) state_d = FROZEN;
`endif
            default: ;
        endcase
        if (cnt_clear_i) state_d = IDLE;
    end
    // Slots 13-15 are never incremented, so they read back as zero.
    always_comb begin
        for (int i = 0; i < 16; i++) cnt_d[i] = cnt_clear_i ? '0 : cnt_q[i];
        if (accept && !(&cnt_q[cls])) cnt_d[cls] = cnt_q[cls] + 1'b1;
        if (drop && !(&cnt_q[12])) cnt_d[12] = cnt_q[12] + 1'b1;
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
            cnt_value_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            addi_err_q    <= 1'b0;
            addi_err_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cnt_value_q <= cnt_q[cnt_sel_i];
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (cnt_clear_i) begin
                overflow_q    <= 1'b0;
                addi_err_q    <= 1'b0;
                addi_err_pc_q <= '0;
            end else begin
                if (drop) overflow_q <= 1'b1;
                if (addi_mis) begin
                    addi_err_q <= 1'b1;
                    if (!addi_err_q) addi_err_pc_q <= retire_pc_i;
                end
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {retire_pc_i, retire_inst_i};
    end
endmodule

// File: tb/tb_hfrv_retire_monitor.sv
// tb_hfrv_retire_monitor: directed stimulus with hand-computed expectations checked by immediate assertions.
module tb_hfrv_retire_monitor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic [31:0] retire_inst = '0;
    logic        retire_rd_we = 1'b0;
    logic [31:0] retire_rd_wdata = '0;
    logic [31:0] retire_rs1_val = '0;
    logic        cnt_clear = 1'b0;
    logic [3:0]  cnt_sel = '0;
    logic [15:0] cnt_value;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_pc;
    logic [31:0] trace_inst;
    logic        trace_overflow;
    logic        addi_err;
    logic [31:0] addi_err_pc;
    int passed = 0;
    int failed = 0;
    int total  = 0;
    localparam logic [31:0] LUI_I  = 32'h000010B7;
    localparam logic [31:0] ADDI_I = 32'h00500113;
    localparam logic [31:0] BEQ_I  = 32'h00000063;
    localparam logic [31:0] ADD_I  = 32'h002081B3;
    localparam logic [31:0] BAD_I  = 32'hFFF08293;
    localparam logic [31:0] RD0_I  = 32'hFFF08013;
    hfrv_retire_monitor dut (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
        .retire_valid_i(retire_valid), .retire_pc_i(retire_pc), .retire_inst_i(retire_inst),
        .retire_rd_we_i(retire_rd_we), .retire_rd_wdata_i(retire_rd_wdata),
        .retire_rs1_val_i(retire_rs1_val), .cnt_clear_i(cnt_clear), .cnt_sel_i(cnt_sel),
        .cnt_value_o(cnt_value), .trace_valid_o(trace_valid), .trace_ready_i(trace_ready),
        .trace_pc_o(trace_pc), .trace_inst_o(trace_inst), .trace_overflow_o(trace_overflow),
        .addi_err_o(addi_err), .addi_err_pc_o(addi_err_pc)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic retire(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                          input logic [31:0] wdata, input logic [31:0] rs1);
        retire_valid = 1'b1; retire_pc = pc; retire_inst = inst;
        retire_rd_we = we; retire_rd_wdata = wdata; retire_rs1_val = rs1;
        tick();
        retire_valid = 1'b0;
    endtask
    task automatic rd_chk(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        cnt_sel = sel;
        tick();
        chk(tag, {16'h0, cnt_value}, exp);
    endtask
    task automatic pop_chk(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, {31'h0, trace_valid}, 32'h1);
        chk({tag, "_pc"}, trace_pc, pc);
        chk({tag, "_inst"}, trace_inst, inst);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
    endtask
    task automatic drain(input int n);
        trace_ready = 1'b1;
        repeat (n) tick();
        trace_ready = 1'b0;
    endtask
    initial begin
        #12;
        chk("rst_valid", {31'h0, trace_valid}, 32'h0);
        chk("rst_cnt", {16'h0, cnt_value}, 32'h0);
        chk("rst_ovf", {31'h0, trace_overflow}, 32'h0);
        chk("rst_err", {31'h0, addi_err}, 32'h0);
        chk("rst_errpc", addi_err_pc, 32'h0);
        reset_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        retire(32'h100, LUI_I, 1'b1, 32'h1000, 32'h0);
        retire(32'h104, ADDI_I, 1'b1, 32'h5, 32'h0);
        retire(32'h108, BEQ_I, 1'b0, 32'h0, 32'h0);
        rd_chk("cnt_lui", 4'd0, 32'h1);
        rd_chk("cnt_opimm", 4'd7, 32'h1);
        rd_chk("cnt_branch", 4'd4, 32'h1);
        rd_chk("cnt_unused13", 4'd13, 32'h0);
        chk("good_addi_err", {31'h0, addi_err}, 32'h0);
        pop_chk("pop0", 32'h100, LUI_I);
        pop_chk("pop1", 32'h104, ADDI_I);
        pop_chk("pop2", 32'h108, BEQ_I);
        chk("empty_after3", {31'h0, trace_valid}, 32'h0);
        // 17 pushes into a 16-entry FIFO with no reader: the last is dropped
        retire_valid = 1'b1; retire_inst = ADD_I; retire_rd_we = 1'b1;
        for (int i = 0; i < 17; i++) begin
            retire_pc = 32'h1000 + 32'(4 * i);
            tick();
        end
        retire_valid = 1'b0;
        chk("ovf_set", {31'h0, trace_overflow}, 32'h1);
        rd_chk("cnt_drop", 4'd12, 32'h1);
        rd_chk("cnt_op17", 4'd8, 32'h11);
        chk("full_head", trace_pc, 32'h1000);
        retire_valid = 1'b1; retire_pc = 32'h2000; trace_ready = 1'b1;
        tick();
        retire_valid = 1'b0; trace_ready = 1'b0;
        rd_chk("cnt_drop_pushpop", 4'd12, 32'h1);
        for (int i = 0; i < 15; i++) pop_chk("drain", 32'h1004 + 32'(4 * i), ADD_I);
        pop_chk("drain_last", 32'h2000, ADD_I);
        chk("empty_after16", {31'h0, trace_valid}, 32'h0);
        rd_chk("cnt_op18", 4'd8, 32'h12);
        retire(32'h1F0, RD0_I, 1'b1, 32'h0, 32'h10);
        chk("rd0_no_err", {31'h0, addi_err}, 32'h0);
        retire(32'h200, BAD_I, 1'b1, 32'h0E, 32'h10);
        chk("addi_err", {31'h0, addi_err}, 32'h1);
        chk("addi_err_pc", addi_err_pc, 32'h200);
        retire(32'h204, BAD_I, 1'b1, 32'h0, 32'h10);
        chk("addi_err_pc_first", addi_err_pc, 32'h200);
        retire(32'h208, LUI_I, 1'b1, 32'h0, 32'h0);
`ifdef HFRV_MON_STOP_ON_ERR_EN
        rd_chk("cnt_opimm_err", 4'd7, 32'h3);
        rd_chk("cnt_lui_err", 4'd0, 32'h1);
`else
        rd_chk("cnt_opimm_err", 4'd7, 32'h4);
        rd_chk("cnt_lui_err", 4'd0, 32'h2);
`endif
        drain(8);
        // Clear with a concurrent retire, then a retire while the FSM is back in IDLE
        cnt_clear = 1'b1;
        retire(32'h300, LUI_I, 1'b1, 32'h0, 32'h0);
        cnt_clear = 1'b0;
        retire(32'h304, LUI_I, 1'b1, 32'h0, 32'h0);
        chk("clr_err", {31'h0, addi_err}, 32'h0);
        chk("clr_errpc", addi_err_pc, 32'h0);
        chk("clr_ovf", {31'h0, trace_overflow}, 32'h0);
        chk("clr_no_push", {31'h0, trace_valid}, 32'h0);
        rd_chk("clr_lui", 4'd0, 32'h0);
        rd_chk("clr_opimm", 4'd7, 32'h0);
        rd_chk("clr_op", 4'd8, 32'h0);
        rd_chk("clr_drop", 4'd12, 32'h0);
        retire_valid = 1'b1; retire_inst = ADD_I; retire_pc = 32'h400; trace_ready = 1'b1;
        repeat (65535) tick();
        retire_valid = 1'b0;
        rd_chk("cnt_op_max", 4'd8, 32'hFFFF);
        retire(32'h404, ADD_I, 1'b1, 32'h0, 32'h0);
        rd_chk("cnt_op_sat", 4'd8, 32'hFFFF);
        rd_chk("sat_no_drop", 4'd12, 32'h0);
        drain(4);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) retire(32'h500 + 32'(4 * i), LUI_I, 1'b1, 32'h0, 32'h0);
        rd_chk("pre_rst_lui", 4'd0, 32'h5);
        chk("pre_rst_valid", {31'h0, trace_valid}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, trace_valid}, 32'h0);
        chk("async_rst_cnt", {16'h0, cnt_value}, 32'h0);
        chk("async_rst_pc", trace_pc, 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
